// File: rtl/matrix_unflatten_loader.sv
// Assembles a row-major stream of WIDTH-bit words into a packed ROWS x COLS matrix
// and holds it with out_valid until the consumer takes it.
//
// state | meaning
// FILL  | accepting words into out_array at idx, in_ready=1
// FULL  | matrix complete and held, out_valid=1, waiting for out_ready
module matrix_unflatten_loader #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int WIDTH = 32
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   clear,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [WIDTH-1:0]                       in_data,
   output logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]   out_array,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [$clog2(ROWS*COLS+1)-1:0]         word_count
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(N + 1);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;

   // For power-of-two COLS the divide and modulo collapse to bit slices.
   assign row = ROW_W'(idx / IDX_W'(COLS));
   assign col = COL_W'(idx % IDX_W'(COLS));

   assign in_ready  = (state == FILL);
   assign out_valid = (state == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         idx        <= '0;
         word_count <= '0;
         out_array  <= '0;
      end else if (clear) begin
         // Abort the fill but keep whatever is already in the array.
         state      <= FILL;
         idx        <= '0;
         word_count <= '0;
      end else begin
         case (state)
            FILL: begin
               if (in_valid) begin
                  out_array[row][col] <= in_data;
                  if (idx == LAST_IDX) begin
                     state      <= FULL;
                     idx        <= '0;
                     word_count <= FULL_CNT;
                  end else begin
                     idx        <= idx + 1'b1;
                     word_count <= word_count + 1'b1;
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  state      <= FILL;
                  word_count <= '0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_unflatten_loader.sv
// Directed-plus-random bench for matrix_unflatten_loader against a word-list model of the fill.
module tb_matrix_unflatten_loader;

   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int WIDTH = 32;
   localparam int N     = ROWS * COLS;

   logic                                 clk = 1'b0;
   logic                                 rst_n;
   logic                                 clear;
   logic                                 in_valid;
   logic                                 in_ready;
   logic [WIDTH-1:0]                     in_data;
   logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] out_array;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [$clog2(N+1)-1:0]               word_count;

   matrix_unflatten_loader #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_array  (out_array),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Model: element k of the matrix, number of words taken so far, matrix-complete flag.
   logic [WIDTH-1:0] exp_m [N];
   int               cnt;
   bit               full;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_ctrl(input string tag);
      check({tag, ".in_ready"},   32'(in_ready),   32'(!full));
      check({tag, ".out_valid"},  32'(out_valid),  32'(full));
      check({tag, ".word_count"}, 32'(word_count), 32'(cnt));
   endtask

   task automatic check_array(input string tag);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            check($sformatf("%s.arr[%0d][%0d]", tag, r, c), out_array[r][c], exp_m[r*COLS+c]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) exp_m[k] = '0;
      cnt  = 0;
      full = 1'b0;
   endtask

   // One clock: drive inputs, apply the spec rules to the model at the edge, then compare.
   task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, input logic clr);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      clear     = clr;
      @(posedge clk);
      if (clr) begin
         cnt  = 0;
         full = 1'b0;
      end else if (!full && v) begin
         exp_m[cnt] = d;
         cnt++;
         if (cnt == N) full = 1'b1;
      end else if (full && ordy) begin
         full = 1'b0;
         cnt  = 0;
      end
      #1;
      check_ctrl("cyc");
   endtask

   // mode 0: back-to-back base+k, 1: random gaps base+k, 2: random data, 3: constant base
   task automatic fill(input int mode, input logic [31:0] base);
      int guard;
      logic v;
      logic [31:0] d;
      guard = 0;
      while (!full && guard < 1000) begin
         v = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         case (mode)
            2:       d = $urandom;
            3:       d = base;
            default: d = base + 32'(cnt);
         endcase
         cycle(v, d, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
         guard++;
      end
      check("fill_done", 32'(full), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      model_reset();
      #12;
      check_ctrl("reset");
      check_array("reset");
      rst_n = 1'b1;

      // Consecutive stream 0..63; out_valid must appear right after the 64th accept.
      fill(0, 32'h0);
      check("stream_cycles", 32'(word_count), 32'd64);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            check($sformatf("seq[%0d][%0d]", r, c), out_array[r][c], 32'(8*r+c));

      // Hold FULL while the source keeps pushing.
      for (int i = 0; i < 20; i++) cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      check_array("hold");
      cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      check("handoff.word_count", 32'(word_count), 32'd0);
      check("handoff.in_ready", 32'(in_ready), 32'd1);

      // Random gaps with out_ready noise while not full.
      fill(1, 32'h100);
      check_array("gaps");
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Ten words, then clear alongside a valid word.
      for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
      cycle(1'b1, 32'hBAD0BAD0, 1'b0, 1'b1);
      check("clear.word_count", 32'(word_count), 32'd0);
      fill(2, 32'h0);
      check_array("post_clear");
      // clear together with out_ready in FULL: same outcome as a plain handoff.
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      check_array("clear_handoff");

      // Asynchronous reset between edges after 37 words.
      for (int i = 0; i < 37; i++) cycle(1'b1, $urandom | 32'h1, 1'b0, 1'b0);
      #3;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      model_reset();
      #1;
      check_ctrl("async_rst");
      check_array("async_rst");
      #2;
      rst_n = 1'b1;

      // Back-to-back matrices with a one-cycle wait before handoff.
      fill(3, 32'hAAAAAAAA);
      check_array("A_full0");
      cycle(1'b1, 32'h55555555, 1'b0, 1'b0);
      check_array("A_full1");
      cycle(1'b1, 32'h55555555, 1'b1, 1'b0);
      check_array("A_handoff");
      check("dead_cycle.word_count", 32'(word_count), 32'd0);
      cycle(1'b1, 32'h55555555, 1'b0, 1'b0);
      check("B_first.word_count", 32'(word_count), 32'd1);
      fill(3, 32'h55555555);
      for (int k = 0; k < N; k++)
         check($sformatf("B[%0d]", k), out_array[k/COLS][k%COLS], 32'h55555555);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/matrix_unflatten_loader.md
Name: matrix_unflatten_loader

Overview:
- Receives a stream of 32-bit words over a valid/ready handshake and assembles them into a packed 8x8x32 matrix.
- This is the inverse of the design's matrix flattening path. Word k lands at row k/8, column k%8, which is bit slice [32k+31:32k] of the equivalent 2048-bit flat vector.
- Sits between the HPS/bus-side word source and the compute datapath. It presents a complete, stable matrix with out_valid until the consumer accepts it.

Parameters:
- ROWS, 8, number of matrix rows (outer index).
- COLS, 8, number of matrix columns (middle index).
- WIDTH, 32, bits per element.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort of the current fill; highest priority after reset.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  element word, row-major order.
- out_array  output  [ROWS-1:0][COLS-1:0][WIDTH-1:0]  assembled matrix, registered.
- out_valid  output  1  out_array is complete and stable.
- out_ready  input  1  consumer accepts out_array.
- word_count  output  $clog2(ROWS*COLS+1)  words accepted in the current fill (0..ROWS*COLS).

Behaviour:
- Reset (rst_n=0, asynchronous): state=FILL, write index idx=0, word_count=0, out_valid=0, in_ready=1, all out_array elements=0.
- Accept event: in_valid && in_ready at a rising edge.
- Two states, FILL and FULL.
- FILL:
  - in_ready=1, out_valid=0.
  - On accept: out_array[idx/COLS][idx%COLS] <= in_data, idx <= idx+1, word_count <= word_count+1.
  - When the accepted word has idx == ROWS*COLS-1, go to FULL. idx wraps to 0 and word_count becomes ROWS*COLS.
- FULL:
  - in_ready=0 and out_valid=1. out_array is held bit-stable; in_data and in_valid are ignored.
  - On out_valid && out_ready: go to FILL, word_count <= 0.
- Latency:
  - out_valid rises in the cycle after the edge that accepted the last word.
  - in_ready rises in the cycle after the out_ready handshake. There is no same-cycle pass-through: a word presented during the handoff cycle is not accepted because in_ready=0.
- Throughput: one word per cycle in FILL. A full matrix costs ROWS*COLS accept cycles plus at least one handoff cycle.
- All outputs are driven from registers. in_ready and out_valid are decoded directly from the state register, with no combinational path from inputs.
- Element writes on refill: out_array elements are not cleared on handoff. They are overwritten one by one during the next FILL, so partially refilled contents are a mix of old and new. Consumers use the array only while out_valid=1.
- clear=1 at an edge, in any state:
  - state=FILL, idx=0, word_count=0, out_valid=0.
  - Any concurrent accept or out handshake is discarded.
  - out_array is unchanged.
- clear and out_ready both high in FULL: clear wins; the result is identical to out_ready alone.
- in_valid deasserted mid-fill: idx and word_count hold and there is no timeout. Gaps of any length are legal.
- in_valid high in FULL: no effect, no error. The source must honour in_ready.
- out_ready high while out_valid=0: ignored.
- Reset asserted mid-fill or mid-FULL: immediate return to the reset values above. A partial matrix is lost.
- Index arithmetic:
  - idx is $clog2(ROWS*COLS) bits wide.
  - Row and column are derived from idx by division/modulo by COLS. For power-of-two COLS these reduce to bit slices.
  - No write ever targets an index >= ROWS*COLS.

Test Plan:
- Reset then stream words 0x00000000..0x0000003F with in_valid held high -> 64 accepts on consecutive cycles; out_valid=1 on the cycle after the 64th; out_array[r][c] == 8r+c for all r,c; in_ready=0 and word_count=64 while FULL.
- Hold out_ready=0 for 20 cycles in FULL while driving in_valid=1 with in_data=0xDEADBEEF -> out_array unchanged, in_ready stays 0. Then pulse out_ready -> out_valid=0 and in_ready=1 next cycle, word_count=0.
- Random in_valid gaps (about 50% duty) with words 0x100+k -> identical final matrix; word_count tracks accepts exactly; out_valid asserts only after the 64th accept.
- Accept 10 words, assert clear for one cycle alongside in_valid -> that word is discarded, word_count=0. The next 64 words fill from [0][0]; the final array holds only post-clear data.
- Assert rst_n=0 asynchronously mid-fill at word 37 (between clock edges) -> out_valid=0, in_ready=1, word_count=0, all out_array elements 0 immediately, without waiting for a clock edge.
- Back-to-back matrices A (all 0xAAAAAAAA) then B (all 0x55555555), with out_ready asserted one cycle into FULL -> A observed stable for the whole FULL period; exactly one dead cycle between A's handoff and B's first accept; B complete and correct.
